// File: rtl/fft_seq_ctrl.sv
// Address/control sequencer for an in-place radix-2 DIF FFT: per-stage read pairs, twiddle index, delayed write-back.
// Optional natural-order unload phase is built when FFT_SEQ_BITREV_EN is defined.
module fft_seq_ctrl #(
    parameter int LOG2N    = 4,
    parameter int PIPE_LAT = 1,
    localparam int SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
`ifdef FFT_SEQ_BITREV_EN
    output logic             out_valid,
    output logic [LOG2N-1:0] out_addr,
`endif
    output logic [2:0]       dbg_state_o
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int TW   = LOG2N - 1;
    localparam int CW   = (LOG2N > $clog2(PIPE_LAT + 1)) ? LOG2N : $clog2(PIPE_LAT + 1);
    localparam int PW   = 2 * LOG2N + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_UNLOAD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q is shared: butterfly index in RUN, drain count in DRAIN, unload index in UNLOAD.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PIPE_LAT - 1)) begin
                    cnt_d = '0;
                    if (stage_q != SW'(LOG2N - 1)) begin
                        stage_d = stage_q + 1'b1;
                        state_d = S_RUN;
                    end else begin
`ifdef FFT_SEQ_BITREV_EN
                        state_d = S_UNLOAD;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_UNLOAD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // mask = span-1; k above the mask is the group, doubled to skip the partner half.
    logic [LOG2N-1:0] k, mask, j, addr_a, addr_b;

    always_comb begin
        k      = cnt_q[LOG2N-1:0];
        mask   = {LOG2N{1'b1}} >> ({1'b0, stage_q} + 1'b1);
        j      = k & mask;
        addr_a = ((k & ~mask) << 1) | j;
        addr_b = addr_a + (mask + 1'b1);
    end

    assign rd_en       = (state_q == S_RUN);
    assign rd_addr_a   = rd_en ? addr_a : '0;
    assign rd_addr_b   = rd_en ? addr_b : '0;
    assign tw_addr     = rd_en ? TW'(j << stage_q) : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign stage       = stage_q;
    assign dbg_state_o = state_q;

    logic [PW-1:0] pipe_q [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = pipe_q[PIPE_LAT-1];

`ifdef FFT_SEQ_BITREV_EN
    logic [LOG2N-1:0] k_rev;

    always_comb begin
        k_rev = '0;
        for (int i = 0; i < LOG2N; i++) k_rev[i] = k[LOG2N-1-i];
    end

    assign out_valid = (state_q == S_UNLOAD);
    assign out_addr  = out_valid ? k_rev : '0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: address trace, write alignment, start filtering, async abort, optional unload.
module tb_fft_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v;

    always #5 clk = ~clk;

`ifdef FFT_SEQ_BITREV_EN
    localparam int UNL = 16;
`else
    localparam int UNL = 0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] stage;
        logic       rd_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] tw;
        logic       wr_en;
        logic [3:0] wa;
        logic [3:0] wb;
        logic [2:0] st;
    } obs_t;

    obs_t obs [2];

    // Instance 0: PIPE_LAT=1, instance 1: PIPE_LAT=3, both N=16.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       busy, done, rd_en, wr_en;
        logic [1:0] stage;
        logic [3:0] ra, rb, wa, wb;
        logic [2:0] tw, st;
`ifdef FFT_SEQ_BITREV_EN
        logic       ov;
        logic [3:0] oa;
`endif
        fft_seq_ctrl #(.LOG2N(4), .PIPE_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]),
            .busy(busy), .done(done), .stage(stage),
            .rd_en(rd_en), .rd_addr_a(ra), .rd_addr_b(rb), .tw_addr(tw),
            .wr_en(wr_en), .wr_addr_a(wa), .wr_addr_b(wb),
`ifdef FFT_SEQ_BITREV_EN
            .out_valid(ov), .out_addr(oa),
`endif
            .dbg_state_o(st)
        );
        assign obs[g] = {busy, done, stage, rd_en, ra, rb, tw, wr_en, wa, wb, st};
    end

`ifdef FFT_SEQ_BITREV_EN
    logic       start_br, br_busy, br_done, br_rd, br_wr, br_ov;
    logic [1:0] br_stage, br_tw;
    logic [2:0] br_ra, br_rb, br_wa, br_wb, br_oa, br_st;
    int         br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_seq_ctrl #(.LOG2N(3), .PIPE_LAT(1)) u_br (
        .clk(clk), .rst_n(rst_n), .start(start_br),
        .busy(br_busy), .done(br_done), .stage(br_stage),
        .rd_en(br_rd), .rd_addr_a(br_ra), .rd_addr_b(br_rb), .tw_addr(br_tw),
        .wr_en(br_wr), .wr_addr_a(br_wa), .wr_addr_b(br_wb),
        .out_valid(br_ov), .out_addr(br_oa),
        .dbg_state_o(br_st)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Start sampled at edge 0; observation c is taken 1 time unit into cycle c.
    task automatic run_fft(input int sel, input int lat, input int x1, input int x2);
        int   exp_done, per, s, k, span, ea, eb, etw, rd_cnt, wr_cnt, done_cnt;
        int   exp_rd, exp_wr;
        logic hen [0:127];
        logic [3:0] ha [0:127];
        logic [3:0] hb [0:127];
        obs_t o;
        per      = 8 + lat;
        exp_done = 4 * per + 1 + UNL;
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            hen[i] = 1'b0;
            ha[i]  = '0;
            hb[i]  = '0;
        end
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        for (int c = 1; c <= exp_done + 6; c++) begin
            o = obs[sel];
            s = (c - 1) / per;
            k = (c - 1) % per;
            exp_rd = (c <= 4 * per && k < 8) ? 1 : 0;
            check_eq($sformatf("i%0d rd_en c%0d", sel, c), 32'(o.rd_en), exp_rd);
            check_eq($sformatf("i%0d busy c%0d", sel, c), 32'(o.busy), (c <= exp_done) ? 1 : 0);
            check_eq($sformatf("i%0d done c%0d", sel, c), 32'(o.done), (c == exp_done) ? 1 : 0);
            hen[c] = o.rd_en;
            ha[c]  = o.ra;
            hb[c]  = o.rb;
            if (o.rd_en && exp_rd == 1) begin
                span = 16 >> (s + 1);
                ea   = (k / span) * 2 * span + (k % span);
                eb   = ea + span;
                etw  = ((k % span) << s) % 8;
                check_eq($sformatf("i%0d rd_addr_a c%0d", sel, c), 32'(o.ra), ea);
                check_eq($sformatf("i%0d rd_addr_b c%0d", sel, c), 32'(o.rb), eb);
                check_eq($sformatf("i%0d tw_addr c%0d", sel, c), 32'(o.tw), etw);
                check_eq($sformatf("i%0d stage c%0d", sel, c), 32'(o.stage), s);
                rd_cnt++;
            end
            exp_wr = (c > lat) ? 32'(hen[c-lat]) : 0;
            check_eq($sformatf("i%0d wr_en c%0d", sel, c), 32'(o.wr_en), exp_wr);
            if (o.wr_en && exp_wr == 1) begin
                check_eq($sformatf("i%0d wr_addr_a c%0d", sel, c), 32'(o.wa), 32'(ha[c-lat]));
                check_eq($sformatf("i%0d wr_addr_b c%0d", sel, c), 32'(o.wb), 32'(hb[c-lat]));
            end
            if (o.wr_en) wr_cnt++;
            if (o.done) done_cnt++;
            start_v[sel] = (c == x1 || c == x2);
            @(posedge clk); #1;
        end
        start_v[sel] = 1'b0;
        check_eq($sformatf("i%0d rd count", sel), rd_cnt, 32);
        check_eq($sformatf("i%0d wr count", sel), wr_cnt, 32);
        check_eq($sformatf("i%0d done pulses", sel), done_cnt, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 2'b11;
`ifdef FFT_SEQ_BITREV_EN
        start_br = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check_eq($sformatf("i%0d reset outputs", g), 32'(obs[g]), 0);
        rst_n   = 1'b1;
        start_v = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("i%0d idle busy", g), 32'(obs[g].busy), 0);
            check_eq($sformatf("i%0d idle state", g), 32'(obs[g].st), 0);
        end

        run_fft(0, 1, 0, 0);
        run_fft(1, 3, 0, 0);
        run_fft(0, 1, 5, 4 * 9 + 1 + UNL);

        // Abort in the middle of stage 2 (cycle 22), reset asserted between edges.
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check_eq("abort pre stage", 32'(obs[0].stage), 2);
        check_eq("abort pre rd_en", 32'(obs[0].rd_en), 1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort outputs", 32'(obs[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check_eq($sformatf("post abort wr_en c%0d", c), 32'(obs[0].wr_en), 0);
            check_eq($sformatf("post abort busy c%0d", c), 32'(obs[0].busy), 0);
            @(posedge clk); #1;
        end
        run_fft(0, 1, 0, 0);

`ifdef FFT_SEQ_BITREV_EN
        begin
            int n, done_c;
            n      = 0;
            done_c = 0;
            start_br = 1'b1;
            @(posedge clk); #1;
            start_br = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                if (br_ov) begin
                    if (n < 8) check_eq($sformatf("unload addr %0d", n), 32'(br_oa), br_exp[n]);
                    check_eq($sformatf("unload cycle %0d", n), c, 16 + n);
                    n++;
                end
                if (br_done) done_c = c;
                @(posedge clk); #1;
            end
            check_eq("unload count", n, 8);
            check_eq("unload done cycle", done_c, 24);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
